// File: rtl/ram_if2_pkg.sv
// ram_if2_pkg: shared constants and transfer FSM states for the ram_if2 line bridge
package ram_if2_pkg;
  localparam int ADDR_W = 13;
  localparam int LINE_BYTES = 8;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int BEAT_W = $clog2(LINE_BYTES);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
endpackage

// File: rtl/ram_if2_line_buf.sv
// ram_if2_line_buf: line register with byte-lane read capture and registered write-byte select
module ram_if2_line_buf #(
  parameter int LINE_BYTES = ram_if2_pkg::LINE_BYTES
) (
  input  logic                           cache_clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [8*LINE_BYTES-1:0]        wdata_c,
  input  logic                           cap,
  input  logic                           fin,
  input  logic                           adv,
  input  logic [$clog2(LINE_BYTES)-1:0]  sel,
  input  logic [7:0]                     rdata_r,
  output logic [8*LINE_BYTES-1:0]        rdata_c,
  output logic [7:0]                     wdata_r
);
  logic [8*LINE_BYTES-1:0] line, merged;
  logic [$clog2(LINE_BYTES)-1:0] nxt;
  // line with the current RAM byte dropped into lane sel; nxt is the lane driven after this beat
  always_comb begin
    merged = line;
    merged[sel*8 +: 8] = rdata_r;
    nxt = sel + 1'b1;
  end
  // working line, published read line (only on the final read beat) and the RAM write byte
  always_ff @(posedge cache_clk) begin
    if (!reset) begin
      line <= '0;
      rdata_c <= '0;
      wdata_r <= '0;
    end else begin
      line <= load ? wdata_c : cap ? merged : line;
      rdata_c <= fin ? merged : rdata_c;
      wdata_r <= load ? wdata_c[7:0] : adv ? line[nxt*8 +: 8] : wdata_r;
    end
  end
endmodule

// File: rtl/ram_if2.sv
// ram_if2: 64-bit cache line <-> byte-wide RAM burst bridge; RAM_IF2_ADDR_INC_EN steps addr_r per beat
module ram_if2 #(
  parameter int ADDR_W = ram_if2_pkg::ADDR_W,
  parameter int LINE_BYTES = ram_if2_pkg::LINE_BYTES
) (
  input  logic                    cache_clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr_c,
  input  logic [8*LINE_BYTES-1:0] wdata_c,
  input  logic                    rd,
  input  logic                    wr,
  output logic [8*LINE_BYTES-1:0] rdata_c,
  output logic                    ack,
  output logic [ADDR_W-1:0]       addr_r,
  output logic                    rnw,
  output logic [7:0]              wdata_r,
  output logic                    aval,
  input  logic [7:0]              rdata_r,
  input  logic                    rack
);
  import ram_if2_pkg::*;
  localparam int BW = $clog2(LINE_BYTES);
  localparam logic [BW-1:0] LAST = BW'(LINE_BYTES - 1);
  state_t state, state_n;
  logic [BW-1:0] k;
  logic start, beat, last;
  logic [ADDR_W-1:0] base;
  // request acceptance, beat strobes and next state; write wins when both requests are high
  always_comb begin
    start = state == IDLE && (rd || wr);
    beat = state == XFER && rack;
    last = beat && k == LAST;
    base = addr_c & ~ADDR_W'(LINE_BYTES - 1);
    state_n = start ? XFER : last ? DONE : state == DONE ? IDLE : state;
  end
  // state register
  always_ff @(posedge cache_clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // beat counter and registered RAM-side / handshake outputs
  always_ff @(posedge cache_clk) begin
    if (!reset) begin
      k <= '0;
      aval <= 1'b0;
      ack <= 1'b0;
      rnw <= 1'b1;
      addr_r <= '0;
    end else begin
      k <= start ? '0 : beat ? k + 1'b1 : k;
      aval <= state_n == XFER;
      ack <= last;
      rnw <= start ? !wr : rnw;
`ifdef RAM_IF2_ADDR_INC_EN
      addr_r <= start ? base : (beat && !last) ? addr_r + 1'b1 : addr_r;
`else
      addr_r <= start ? base : addr_r;
`endif
    end
  end
  ram_if2_line_buf #(.LINE_BYTES(LINE_BYTES)) u_buf (
    .cache_clk(cache_clk),
    .reset(reset),
    .load(start),
    .wdata_c(wdata_c),
    .cap(beat && rnw),
    .fin(last && rnw),
    .adv(beat),
    .sel(k),
    .rdata_r(rdata_r),
    .rdata_c(rdata_c),
    .wdata_r(wdata_r)
  );
endmodule

// File: tb/tb_ram_if2.sv
// tb_ram_if2: directed scoreboard bench for ram_if2 (beats queued at request, popped on rack)
module tb_ram_if2;
  logic cache_clk = 1'b0;
  logic reset = 1'b0;
  logic [12:0] addr_c = '0;
  logic [63:0] wdata_c = '0;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic [63:0] rdata_c;
  logic ack, rnw, aval;
  logic [12:0] addr_r;
  logic [7:0] wdata_r;
  logic [7:0] rdata_r = '0;
  logic rack = 1'b0;
  typedef struct packed {logic [12:0] a; logic rnw; logic [7:0] wb; logic [7:0] rb;} beat_t;
  beat_t bq[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rd = '0;
  localparam logic [31:0] ONES = 32'hffff_ffff;
  localparam logic [31:0] ALT = 32'h5555_5555;
`ifdef RAM_IF2_ADDR_INC_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif

  ram_if2 dut (
    .cache_clk(cache_clk), .reset(reset), .addr_c(addr_c), .wdata_c(wdata_c),
    .rd(rd), .wr(wr), .rdata_c(rdata_c), .ack(ack), .addr_r(addr_r), .rnw(rnw),
    .wdata_r(wdata_r), .aval(aval), .rdata_r(rdata_r), .rack(rack)
  );

  always #5 cache_clk = ~cache_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [12:0] beat_addr(input logic [12:0] base, input int b);
    return base + (INC ? 13'(b) : 13'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic w, input logic r, input logic [12:0] a, input logic [63:0] wd,
                     input logic [63:0] line, input logic [31:0] pat, input logic keep_rd,
                     input int abort_at);
    logic [12:0] base;
    logic [63:0] exp_line;
    int lat, ones, n, beats;
    bit done, aborted;
    base = a & ~13'h7;
    lat = 0;
    ones = 0;
    while (ones < 8) begin
      if (pat[lat % 32]) ones++;
      lat++;
    end
    for (int b = 0; b < 8; b++) bq.push_back('{beat_addr(base, b), !w, wd[8*b +: 8], line[8*b +: 8]});
    exp_line = w ? exp_rd : line;
    addr_c = a;
    wdata_c = wd;
    wr = w;
    rd = r;
    n = 0;
    beats = 0;
    done = 1'b0;
    aborted = 1'b0;
    while (!done && !aborted && n < 64) begin
      @(negedge cache_clk);
      n++;
      addr_c = ~a;
      wdata_c = ~wd;
      if (beats == 8) begin
        chk("ack", ack, 1);
        chk("ack_latency", n, lat + 1);
        chk("aval_done", aval, 0);
        chk("rdata_c_done", rdata_c, exp_line);
        exp_rd = exp_line;
        wr = 1'b0;
        rd = keep_rd;
        rack = 1'b0;
        done = 1'b1;
      end else begin
        chk("ack_early", ack, 0);
        chk("aval", aval, 1);
        chk("rdata_c_hold", rdata_c, exp_rd);
        chk("addr_r", addr_r, bq[0].a);
        chk("rnw", rnw, bq[0].rnw);
        if (w) chk("wdata_r", wdata_r, bq[0].wb);
        rack = pat[(n - 1) % 32];
        rdata_r = rack ? bq[0].rb : 8'($urandom);
        if (rack) begin
          void'(bq.pop_front());
          beats++;
        end
        aborted = beats == abort_at;
      end
    end
    chk("txn_timeout", done || aborted, 1);
    if (done) begin
      @(negedge cache_clk);
      chk("ack_single", ack, 0);
      chk("aval_idle", aval, 0);
    end
  endtask

  initial begin
    rd = 1'b1;
    rack = 1'b1;
    repeat (2) @(negedge cache_clk);
    chk("rst_aval", aval, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rnw", rnw, 1);
    chk("rst_addr_r", addr_r, 0);
    chk("rst_wdata_r", wdata_r, 0);
    chk("rst_rdata_c", rdata_c, 0);
    rd = 1'b0;
    rack = 1'b0;
    reset = 1'b1;
    @(negedge cache_clk);
    txn(1'b0, 1'b1, 13'h010F, 64'h0, 64'h90786F5E4D3C2B1A, ONES, 1'b0, -1);
    txn(1'b1, 1'b0, 13'h0A55, 64'h1234567890ABCDEF, 64'h0, ONES, 1'b0, -1);
    txn(1'b0, 1'b1, 13'h1FFB, 64'h0, 64'hC0FFEE00DEADBEEF, ALT, 1'b0, -1);
    txn(1'b1, 1'b1, 13'h0040, 64'hA5A55A5A0F0FF0F0, 64'h0, ONES, 1'b1, -1);
    txn(1'b0, 1'b1, 13'h0080, 64'h0, 64'h0123456789ABCDEF, ONES, 1'b0, -1);
    txn(1'b0, 1'b1, 13'h0333, 64'h0, 64'hFFEEDDCCBBAA9988, ONES, 1'b0, 4);
    @(negedge cache_clk);
    reset = 1'b0;
    rd = 1'b0;
    rack = 1'b0;
    bq.delete();
    @(negedge cache_clk);
    chk("mid_rst_aval", aval, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_rnw", rnw, 1);
    chk("mid_rst_addr_r", addr_r, 0);
    chk("mid_rst_wdata_r", wdata_r, 0);
    chk("mid_rst_rdata_c", rdata_c, 0);
    exp_rd = '0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge cache_clk);
      chk("post_rst_ack", ack, 0);
      chk("post_rst_aval", aval, 0);
    end
    txn(1'b0, 1'b1, 13'h0333, 64'h0, 64'h1122334455667788, ONES, 1'b0, -1);
    rack = 1'b1;
    rdata_r = 8'hFF;
    repeat (3) begin
      @(negedge cache_clk);
      chk("stray_aval", aval, 0);
      chk("stray_ack", ack, 0);
      chk("stray_addr_r", addr_r, beat_addr(13'h0330, 7));
      chk("stray_rdata_c", rdata_c, 64'h1122334455667788);
    end
    rack = 1'b0;
    txn(1'b1, 1'b0, 13'h1234, 64'hFEDCBA9876543210, 64'h0, ALT, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
